// File: rtl/exception_module.sv
// exception_module: registered special-case detector for the 8-bit FPU.
// Format: bit 7 sign, bits 6:3 exponent (bias 7), bits 2:0 mantissa.
// Flags operand combinations that must bypass the arithmetic datapath and
// supplies the IEEE-style special result, one cycle after sampling.
module exception_module (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] op,
    input  logic [7:0] in0,
    input  logic [7:0] in1,
    output logic       out,
    output logic [7:0] special_result,
    output logic [2:0] exc_type
);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    localparam logic [7:0] NAN_CANON = 8'h7C;
    localparam logic [6:0] INF_MAG   = 7'h78;

    localparam logic [2:0] EXC_NONE    = 3'b000;
    localparam logic [2:0] EXC_INVALID = 3'b100;
    localparam logic [2:0] EXC_DIVZERO = 3'b010;
    localparam logic [2:0] EXC_INFOP   = 3'b001;

    logic       a_zero, a_inf, a_nan;
    logic       b_zero, b_inf, b_nan;
    logic       a_finite_nz;
    logic       b_sign_eff;
    logic       sign_xor;
    logic       is_addsub;

    logic       nxt_out;
    logic [7:0] nxt_result;
    logic [2:0] nxt_exc;

    assign a_zero      = (in0[6:3] == 4'h0) && (in0[2:0] == 3'b000);
    assign a_inf       = (in0[6:3] == 4'hF) && (in0[2:0] == 3'b000);
    assign a_nan       = (in0[6:3] == 4'hF) && (in0[2:0] != 3'b000);
    assign b_zero      = (in1[6:3] == 4'h0) && (in1[2:0] == 3'b000);
    assign b_inf       = (in1[6:3] == 4'hF) && (in1[2:0] == 3'b000);
    assign b_nan       = (in1[6:3] == 4'hF) && (in1[2:0] != 3'b000);
    assign a_finite_nz = (in0[6:3] != 4'hF) && !a_zero;

    assign is_addsub   = (op == OP_ADD) || (op == OP_SUB);
    assign b_sign_eff  = (op == OP_SUB) ? ~in1[7] : in1[7];
    assign sign_xor    = in0[7] ^ in1[7];

    // Priority classification of the current operands into flag, type and result.
    always_comb begin
        nxt_out    = 1'b0;
        nxt_exc    = EXC_NONE;
        nxt_result = 8'h00;
        if (a_nan || b_nan) begin
            nxt_out    = 1'b1;
            nxt_exc    = EXC_INVALID;
            nxt_result = NAN_CANON;
        end else if (is_addsub && a_inf && b_inf && (in0[7] != b_sign_eff)) begin
            nxt_out    = 1'b1;
            nxt_exc    = EXC_INVALID;
            nxt_result = NAN_CANON;
        end else if ((op == OP_MUL) && ((a_inf && b_zero) || (a_zero && b_inf))) begin
            nxt_out    = 1'b1;
            nxt_exc    = EXC_INVALID;
            nxt_result = NAN_CANON;
        end else if ((op == OP_DIV) && ((a_zero && b_zero) || (a_inf && b_inf))) begin
            nxt_out    = 1'b1;
            nxt_exc    = EXC_INVALID;
            nxt_result = NAN_CANON;
        end else if ((op == OP_DIV) && a_finite_nz && b_zero) begin
            nxt_out    = 1'b1;
            nxt_exc    = EXC_DIVZERO;
            nxt_result = {sign_xor, INF_MAG};
        end else if (a_inf || b_inf) begin
            nxt_out = 1'b1;
            nxt_exc = EXC_INFOP;
            if (is_addsub) begin
                // Both-inf here implies matching effective signs, so in0's sign is correct.
                nxt_result = a_inf ? {in0[7], INF_MAG} : {b_sign_eff, INF_MAG};
            end else if ((op == OP_DIV) && b_inf) begin
                nxt_result = {sign_xor, 7'h00};
            end else begin
                nxt_result = {sign_xor, INF_MAG};
            end
        end
    end

    // Register the classification; reset clears outputs asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out            <= 1'b0;
            special_result <= 8'h00;
            exc_type       <= EXC_NONE;
        end else begin
            out            <= nxt_out;
            special_result <= nxt_result;
            exc_type       <= nxt_exc;
        end
    end

endmodule

// File: tb/tb_exception_module.sv
// tb_exception_module: directed and random checks of exception_module
// against a rule-level reference model.
module tb_exception_module;

    logic       clk;
    logic       rst_n;
    logic [1:0] op;
    logic [7:0] in0;
    logic [7:0] in1;
    logic       out;
    logic [7:0] special_result;
    logic [2:0] exc_type;

    int vectors;
    int miscompares;

    exception_module dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .op             (op),
        .in0            (in0),
        .in1            (in1),
        .out            (out),
        .special_result (special_result),
        .exc_type       (exc_type)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Operand category: 0 zero, 1 subnormal, 2 normal, 3 inf, 4 NaN
    function automatic int kind(input logic [7:0] v);
        int e;
        int m;
        e = int'(v[6:3]);
        m = int'(v[2:0]);
        if (e == 0) return (m == 0) ? 0 : 1;
        if (e == 15) return (m == 0) ? 3 : 4;
        return 2;
    endfunction

    // Expected {out, exc_type, special_result} from the priority rules
    function automatic logic [11:0] model(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b);
        int ka;
        int kb;
        bit sa;
        bit sb;
        bit sx;
        ka = kind(a);
        kb = kind(b);
        sa = a[7];
        sb = (o == 2'd1) ? !b[7] : b[7];
        sx = a[7] ^ b[7];
        if (ka == 4 || kb == 4) return {1'b1, 3'b100, 8'h7C};
        if (o <= 2'd1 && ka == 3 && kb == 3 && sa != sb) return {1'b1, 3'b100, 8'h7C};
        if (o == 2'd2 && ((ka == 3 && kb == 0) || (ka == 0 && kb == 3))) return {1'b1, 3'b100, 8'h7C};
        if (o == 2'd3 && ((ka == 0 && kb == 0) || (ka == 3 && kb == 3))) return {1'b1, 3'b100, 8'h7C};
        if (o == 2'd3 && (ka == 1 || ka == 2) && kb == 0) return {1'b1, 3'b010, sx ? 8'hF8 : 8'h78};
        if (ka == 3 || kb == 3) begin
            if (o <= 2'd1) begin
                if (ka == 3) return {1'b1, 3'b001, sa ? 8'hF8 : 8'h78};
                return {1'b1, 3'b001, sb ? 8'hF8 : 8'h78};
            end
            if (o == 2'd3 && kb == 3) return {1'b1, 3'b001, sx ? 8'h80 : 8'h00};
            return {1'b1, 3'b001, sx ? 8'hF8 : 8'h78};
        end
        return {1'b0, 3'b000, 8'h00};
    endfunction

    task automatic check(input string tag, input logic [11:0] exp);
        logic [11:0] obs;
        obs = {out, exc_type, special_result};
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s op=%0d in0=%h in1=%h observed=%h expected=%h", tag, op, in0, in1, obs, exp);
        end
    endtask

    // Drive at negedge, check one cycle later (#1 after the registering edge)
    task automatic apply(input string tag, input logic [1:0] o, input logic [7:0] a, input logic [7:0] b,
                         input logic [11:0] exp_const, input bit use_const);
        logic [11:0] exp;
        @(negedge clk);
        op  = o;
        in0 = a;
        in1 = b;
        exp = use_const ? exp_const : model(o, a, b);
        @(posedge clk);
        #1;
        check(tag, exp);
    endtask

    logic [7:0] fin [3];
    logic [7:0] specials [8];

    initial begin
        vectors     = 0;
        miscompares = 0;
        fin[0] = 8'h38; fin[1] = 8'h40; fin[2] = 8'h01;
        specials[0] = 8'h00; specials[1] = 8'h80; specials[2] = 8'h78; specials[3] = 8'hF8;
        specials[4] = 8'h79; specials[5] = 8'hFF; specials[6] = 8'h01; specials[7] = 8'hB8;

        rst_n = 1'b0;
        op    = 2'd0;
        in0   = 8'h78;
        in1   = 8'h00;
        #12;
        check("reset_state", 12'h000);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases with hand-derived expectations
        apply("add_inf",       2'd0, 8'h78, 8'h00, {1'b1, 3'b001, 8'h78}, 1);
        apply("sub_inf_inf",   2'd1, 8'h78, 8'h78, {1'b1, 3'b100, 8'h7C}, 1);
        apply("add_inf_ninf",  2'd0, 8'h78, 8'hF8, {1'b1, 3'b100, 8'h7C}, 1);
        apply("sub_inf_ninf",  2'd1, 8'h78, 8'hF8, {1'b1, 3'b001, 8'h78}, 1);
        apply("sub_fin_inf",   2'd1, 8'h38, 8'h78, {1'b1, 3'b001, 8'hF8}, 1);
        apply("mul_zero_inf",  2'd2, 8'h00, 8'hF8, {1'b1, 3'b100, 8'h7C}, 1);
        apply("mul_one_ninf",  2'd2, 8'h38, 8'hF8, {1'b1, 3'b001, 8'hF8}, 1);
        apply("div_by_zero",   2'd3, 8'hB8, 8'h00, {1'b1, 3'b010, 8'hF8}, 1);
        apply("div_sub_zero",  2'd3, 8'h01, 8'h80, {1'b1, 3'b010, 8'hF8}, 1);
        apply("div_zero_zero", 2'd3, 8'h00, 8'h00, {1'b1, 3'b100, 8'h7C}, 1);
        apply("div_inf_inf",   2'd3, 8'hF8, 8'h78, {1'b1, 3'b100, 8'h7C}, 1);
        apply("div_fin_inf",   2'd3, 8'h38, 8'h78, {1'b1, 3'b001, 8'h00}, 1);
        apply("div_nfin_inf",  2'd3, 8'hB8, 8'h78, {1'b1, 3'b001, 8'h80}, 1);
        apply("div_inf_zero",  2'd3, 8'hF8, 8'h00, {1'b1, 3'b001, 8'hF8}, 1);
        apply("add_zero_zero", 2'd0, 8'h00, 8'h00, {1'b0, 3'b000, 8'h00}, 1);

        // NaN on either port and finite pairs, for every op
        for (int o = 0; o < 4; o++) begin
            apply("nan_in1", 2'(o), 8'h38, 8'h79, {1'b1, 3'b100, 8'h7C}, 1);
            apply("nan_in0", 2'(o), 8'hFF, 8'h00, {1'b1, 3'b100, 8'h7C}, 1);
            for (int i = 0; i < 3; i++)
                apply("finite", 2'(o), fin[i], fin[(i + 1) % 3], {1'b0, 3'b000, 8'h00}, 1);
        end

        // Reset asserted between edges clears outputs at once
        apply("pre_reset", 2'd3, 8'hB8, 8'h00, {1'b1, 3'b010, 8'hF8}, 1);
        @(negedge clk);
        op    = 2'd2;
        in0   = 8'h38;
        in1   = 8'h78;
        rst_n = 1'b0;
        #1;
        check("async_reset", 12'h000);
        @(posedge clk);
        #1;
        check("held_reset", 12'h000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset", {1'b1, 3'b001, 8'h78});

        // Random operands, biased toward special values
        for (int n = 0; n < 400; n++) begin
            logic [7:0] a;
            logic [7:0] b;
            a = ($urandom_range(0, 1) == 0) ? specials[$urandom_range(0, 7)] : 8'($urandom);
            b = ($urandom_range(0, 1) == 0) ? specials[$urandom_range(0, 7)] : 8'($urandom);
            apply("random", 2'($urandom_range(0, 3)), a, b, 12'h000, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
